// File: rtl/neuraedge_tile_pkg.sv
// Shared types and constants for the neuraedge tile mode scheduler.
package neuraedge_tile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_APPLY  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [1:0] PREC_INT8 = 2'd0;
  localparam logic [1:0] PREC_INT4 = 2'd1;
  localparam logic [1:0] PREC_INT2 = 2'd2;
  localparam logic [1:0] PREC_INT1 = 2'd3;

  localparam logic [7:0] THERM_HI_DEFAULT = 8'd85;
  localparam logic [7:0] THERM_LO_DEFAULT = 8'd75;

  // Lane-mask helpers are 32 bits wide; users truncate to their lane count.
  localparam logic [31:0] LANE_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] LANE_LOWEST   = 32'h0000_0001;

  function automatic logic [31:0] lower_half_mask(input int lanes);
    lower_half_mask = (32'h1 << (lanes / 2)) - 32'h1;
  endfunction

endpackage

// File: rtl/tile_mode_scheduler_if.sv
// Configuration request handshake between the host/CSR side and the scheduler.
interface tile_mode_scheduler_if #(
  parameter int LANES = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_precision;
  logic [LANES-1:0] req_lane_mask;
  logic             req_sparsity_en;
  logic [1:0]       req_sparsity_mode;

  modport master (
    output req_valid, req_precision, req_lane_mask, req_sparsity_en, req_sparsity_mode,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_precision, req_lane_mask, req_sparsity_en, req_sparsity_mode,
    output req_ready
  );
endinterface

// File: rtl/tile_thermal_throttle.sv
// Registered hysteresis comparator: sets at or above therm_hi, clears at or below therm_lo.
module tile_thermal_throttle (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] temperature,
  input  logic [7:0] therm_hi,
  input  logic [7:0] therm_lo,
  output logic       throttled_next
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      throttled_next <= 1'b0;
    end else if (temperature >= therm_hi) begin
      throttled_next <= 1'b1;
    end else if (temperature <= therm_lo) begin
      throttled_next <= 1'b0;
    end
  end

endmodule

// File: rtl/tile_mode_scheduler.sv
// Sequences tile configuration changes: stall, drain, apply atomically, settle, release.
// Thermal throttling reuses the same sequence and narrows the effective lane mask.
module tile_mode_scheduler
  import neuraedge_tile_pkg::*;
#(
  parameter int         DRAIN_CYCLES  = 8,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         LANES         = 4,
  parameter logic [7:0] THERM_HI      = THERM_HI_DEFAULT,
  parameter logic [7:0] THERM_LO      = THERM_LO_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  tile_mode_scheduler_if.slave req,
  input  logic [7:0]           temperature,
  input  logic                 data_valid_in,
  output logic                 data_valid_out,
  output logic                 data_stall,
  output logic [1:0]           precision_mode,
  output logic [LANES-1:0]     lane_active_mask,
  output logic                 sparsity_enable,
  output logic [1:0]           sparsity_mode,
  output logic                 throttled,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [15:0]          switch_count
);

  localparam int CNT_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LANES-1:0] MASK_ALL    = LANES'(LANE_ALL_ONES);
  localparam logic [LANES-1:0] MASK_LOWER  = LANES'(lower_half_mask(LANES));
  localparam logic [LANES-1:0] MASK_LOWEST = LANES'(LANE_LOWEST);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             throttled_next;
  logic             therm_pending;
  logic             accept;
  logic [1:0]       lat_prec;
  logic [LANES-1:0] lat_mask;
  logic             lat_sp_en;
  logic [1:0]       lat_sp_mode;
  logic [LANES-1:0] masked_lanes;
  logic [LANES-1:0] eff_mask;

  tile_thermal_throttle u_therm (
    .clk            (clk),
    .reset          (reset),
    .temperature    (temperature),
    .therm_hi       (THERM_HI),
    .therm_lo       (THERM_LO),
    .throttled_next (throttled_next)
  );

  assign therm_pending  = (throttled_next != throttled);
  assign req.req_ready  = (state == ST_IDLE) && !therm_pending;
  assign accept         = req.req_valid && req.req_ready;
  assign busy           = (state != ST_IDLE);
  assign data_stall     = busy;
  assign data_valid_out = data_valid_in & ~data_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Accept and a pending throttle change are exclusive in IDLE, since req_ready excludes pending.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (accept || therm_pending) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_APPLY;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_APPLY: begin
        cnt_nxt   = '0;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The latched fields persist after apply, so a thermal-only sequence reapplies the current config.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_prec    <= PREC_INT8;
      lat_mask    <= MASK_ALL;
      lat_sp_en   <= 1'b0;
      lat_sp_mode <= 2'd0;
    end else if (accept) begin
      lat_prec    <= req.req_precision;
      lat_mask    <= (req.req_lane_mask == '0) ? MASK_LOWEST : req.req_lane_mask;
      lat_sp_en   <= req.req_sparsity_en;
      lat_sp_mode <= req.req_sparsity_mode;
    end
  end

  always_comb begin
    masked_lanes = lat_mask & (throttled_next ? MASK_LOWER : MASK_ALL);
    eff_mask     = (masked_lanes == '0) ? MASK_LOWEST : masked_lanes;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      precision_mode   <= PREC_INT8;
      lane_active_mask <= MASK_ALL;
      sparsity_enable  <= 1'b0;
      sparsity_mode    <= 2'd0;
      throttled        <= 1'b0;
      switch_count     <= 16'd0;
    end else if (state == ST_APPLY) begin
      precision_mode   <= lat_prec;
      lane_active_mask <= eff_mask;
      sparsity_enable  <= lat_sp_en;
      sparsity_mode    <= lat_sp_mode;
      throttled        <= throttled_next;
      if (switch_count != 16'hFFFF) switch_count <= switch_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= (state == ST_SETTLE) && (cnt == SETTLE_LAST);
      cfg_err <= accept && (req.req_lane_mask == '0);
    end
  end

endmodule

// File: tb/tb_tile_mode_scheduler.sv
// Self-checking bench for tile_mode_scheduler: table-driven requests, a scoreboard of
// expected applied configurations, and hand-written thermal, reset and saturation sequences.
module tb_tile_mode_scheduler;
  import neuraedge_tile_pkg::*;

  localparam int LANES = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       temperature;
  logic             data_valid_in;
  logic             data_valid_out;
  logic             data_stall;
  logic [1:0]       precision_mode;
  logic [LANES-1:0] lane_active_mask;
  logic             sparsity_enable;
  logic [1:0]       sparsity_mode;
  logic             throttled;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [15:0]      switch_count;

  tile_mode_scheduler_if #(.LANES(LANES)) req_if ();

  tile_mode_scheduler #(
    .DRAIN_CYCLES  (8),
    .SETTLE_CYCLES (4),
    .LANES         (LANES),
    .THERM_HI      (THERM_HI_DEFAULT),
    .THERM_LO      (THERM_LO_DEFAULT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req_if),
    .temperature      (temperature),
    .data_valid_in    (data_valid_in),
    .data_valid_out   (data_valid_out),
    .data_stall       (data_stall),
    .precision_mode   (precision_mode),
    .lane_active_mask (lane_active_mask),
    .sparsity_enable  (sparsity_enable),
    .sparsity_mode    (sparsity_mode),
    .throttled        (throttled),
    .busy             (busy),
    .done             (done),
    .cfg_err          (cfg_err),
    .switch_count     (switch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] prec;
    logic [3:0] mask;
    logic       sp_en;
    logic [1:0] sp_mode;
    logic [3:0] exp_mask;
    logic       exp_cfg_err;
    logic       exp_thr;
  } vec_t;

  typedef struct {
    logic [1:0]  prec;
    logic [3:0]  mask;
    logic        sp_en;
    logic [1:0]  sp_mode;
    logic        thr;
    logic [15:0] count;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[5];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  m_prec;
  logic        m_sp_en;
  logic [1:0]  m_sp_mode;
  logic [15:0] m_count;
  logic [1:0]  cur_prec;
  logic [3:0]  cur_mask;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExpected(input logic [1:0] prec, input logic [3:0] mask, input logic sp_en,
                              input logic [1:0] sp_mode, input logic thr);
    exp_t e;
    m_count = (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
    e.prec = prec; e.mask = mask; e.sp_en = sp_en; e.sp_mode = sp_mode;
    e.thr = thr; e.count = m_count;
    sb.push_back(e);
  endtask

  // Called just after the accept edge; follows the sequence through to the done pulse.
  task automatic waitSequence(input string tag, input logic exp_cfg_err);
    exp_t e;
    bit   seen = 0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge clk);
      checkOutput({tag, " data_valid_out"}, 32'(data_valid_out), 32'(cyc >= 13));
      if (cyc == 0) checkOutput({tag, " cfg_err"}, 32'(cfg_err), 32'(exp_cfg_err));
      if (cyc == 1) checkOutput({tag, " cfg_err clear"}, 32'(cfg_err), 32'd0);
      if (cyc == 8) begin
        checkOutput({tag, " prec before apply"}, 32'(precision_mode), 32'(cur_prec));
        checkOutput({tag, " mask before apply"}, 32'(lane_active_mask), 32'(cur_mask));
      end
      if (cyc == 9 && sb.size() > 0) begin
        checkOutput({tag, " prec at apply"}, 32'(precision_mode), 32'(sb[0].prec));
        checkOutput({tag, " mask at apply"}, 32'(lane_active_mask), 32'(sb[0].mask));
      end
      if (done) begin
        seen = 1;
        checkOutput({tag, " done latency"}, 32'(cyc), 32'd13);
        checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
          checkOutput({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({tag, " precision_mode"}, 32'(precision_mode), 32'(e.prec));
          checkOutput({tag, " lane_active_mask"}, 32'(lane_active_mask), 32'(e.mask));
          checkOutput({tag, " sparsity_enable"}, 32'(sparsity_enable), 32'(e.sp_en));
          checkOutput({tag, " sparsity_mode"}, 32'(sparsity_mode), 32'(e.sp_mode));
          checkOutput({tag, " throttled"}, 32'(throttled), 32'(e.thr));
          checkOutput({tag, " switch_count"}, 32'(switch_count), 32'(e.count));
          cur_prec = e.prec;
          cur_mask = e.mask;
        end
      end
    end
    if (!seen) checkOutput({tag, " done timeout"}, 32'd0, 32'd1);
  endtask

  task automatic driveRequest(input vec_t v);
    for (int c = 0; c < 60 && !req_if.req_ready; c++) @(negedge clk);
    checkOutput("req_ready before request", 32'(req_if.req_ready), 32'd1);
    req_if.req_valid         = 1'b1;
    req_if.req_precision     = v.prec;
    req_if.req_lane_mask     = v.mask;
    req_if.req_sparsity_en   = v.sp_en;
    req_if.req_sparsity_mode = v.sp_mode;
    m_prec = v.prec; m_sp_en = v.sp_en; m_sp_mode = v.sp_mode;
    pushExpected(v.prec, v.exp_mask, v.sp_en, v.sp_mode, v.exp_thr);
    @(posedge clk);
    #1 req_if.req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    driveRequest(v);
    waitSequence(tag, v.exp_cfg_err);
  endtask

  task automatic throttleStep(input string tag, input logic [7:0] temp, input logic [3:0] exp_mask,
                              input logic exp_thr);
    @(negedge clk);
    temperature = temp;
    @(negedge clk);
    checkOutput({tag, " req_ready during pending"}, 32'(req_if.req_ready), 32'd0);
    checkOutput({tag, " busy before accept"}, 32'(busy), 32'd0);
    pushExpected(m_prec, exp_mask, m_sp_en, m_sp_mode, exp_thr);
    @(posedge clk);
    waitSequence(tag, 1'b0);
  endtask

  initial begin
    vec_t v;
    bit   any_busy;
    bit   any_done;

    vecs[0] = '{PREC_INT4, 4'hF, 1'b1, 2'd2, 4'hF, 1'b0, 1'b0};
    vecs[1] = '{PREC_INT8, 4'h0, 1'b0, 2'd0, 4'h1, 1'b1, 1'b0};
    vecs[2] = '{PREC_INT1, 4'hA, 1'b1, 2'd1, 4'hA, 1'b0, 1'b0};
    vecs[3] = '{PREC_INT2, 4'h5, 1'b0, 2'd3, 4'h5, 1'b0, 1'b0};
    vecs[4] = '{PREC_INT8, 4'hF, 1'b0, 2'd0, 4'hF, 1'b0, 1'b0};

    reset = 1'b1;
    temperature = 8'd50;
    data_valid_in = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_precision = 2'd0;
    req_if.req_lane_mask = 4'h0;
    req_if.req_sparsity_en = 1'b0;
    req_if.req_sparsity_mode = 2'd0;
    m_prec = PREC_INT8; m_sp_en = 1'b0; m_sp_mode = 2'd0; m_count = 16'd0;
    cur_prec = PREC_INT8; cur_mask = 4'hF;

    repeat (2) @(negedge clk);
    checkOutput("reset precision_mode", 32'(precision_mode), 32'd0);
    checkOutput("reset lane_active_mask", 32'(lane_active_mask), 32'hF);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset switch_count", 32'(switch_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("req_ready after reset", 32'(req_if.req_ready), 32'd1);
    checkOutput("idle data_valid_out", 32'(data_valid_out), 32'd1);

    $display("[TB] table-driven requests");
    for (int i = 0; i < 5; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    $display("[TB] thermal hysteresis");
    throttleStep("heat90", 8'd90, 4'h3, 1'b1);
    @(negedge clk);
    temperature = 8'd80;
    any_busy = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) any_busy = 1;
    end
    checkOutput("temp80 no sequence", 32'(any_busy), 32'd0);
    checkOutput("temp80 mask held", 32'(lane_active_mask), 32'h3);
    checkOutput("temp80 throttled held", 32'(throttled), 32'd1);
    throttleStep("cool70", 8'd70, 4'hF, 1'b0);

    $display("[TB] request and heat in same cycle");
    @(negedge clk);
    temperature = 8'd90;
    v = '{PREC_INT2, 4'h6, 1'b1, 2'd1, 4'h2, 1'b0, 1'b1};
    applyStimulus("fold", v);
    any_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) any_busy = 1;
    end
    checkOutput("fold single sequence", 32'(any_busy), 32'd0);
    v = '{PREC_INT8, 4'hC, 1'b0, 2'd0, 4'h1, 1'b0, 1'b1};
    applyStimulus("throttled zero mask", v);
    throttleStep("cool after fold", 8'd70, 4'hC, 1'b0);

    $display("[TB] reset during drain");
    v = '{PREC_INT1, 4'h9, 1'b1, 2'd3, 4'h9, 1'b0, 1'b0};
    driveRequest(v);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset precision_mode", 32'(precision_mode), 32'd0);
    checkOutput("midreset lane_active_mask", 32'(lane_active_mask), 32'hF);
    checkOutput("midreset sparsity_mode", 32'(sparsity_mode), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset switch_count", 32'(switch_count), 32'd0);
    sb.delete();
    m_prec = PREC_INT8; m_sp_en = 1'b0; m_sp_mode = 2'd0; m_count = 16'd0;
    cur_prec = PREC_INT8; cur_mask = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("req_ready after midreset", 32'(req_if.req_ready), 32'd1);
    any_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) any_done = 1;
    end
    checkOutput("no done after abandoned sequence", 32'(any_done), 32'd0);

    $display("[TB] switch_count saturation");
    @(negedge clk);
    force dut.switch_count = 16'hFFFD;
    @(negedge clk);
    release dut.switch_count;
    m_count = 16'hFFFD;
    @(negedge clk);
    checkOutput("preloaded switch_count", 32'(switch_count), 32'hFFFD);
    for (int i = 0; i < 4; i++) applyStimulus($sformatf("sat%0d", i), vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_mode_scheduler.md
Name: tile_mode_scheduler

Overview:
- Sequences run-time configuration changes into neuraedge_tile_50tops: precision, lane mask and sparsity settings, plus thermal lane throttling.
- The tile's MAC pipeline has no drain of its own, so each change follows the same order:
  1. Stall upstream data.
  2. Drain for a fixed depth.
  3. Apply the new configuration atomically.
  4. Hold for a settle window.
  5. Release the stall.
- Sits between the host/CSR request source and the tile's control pins.

Parameters:
- DRAIN_CYCLES, 8, cycles of forced data idle before apply (must be >= tile pipeline depth, >= 1).
- SETTLE_CYCLES, 4, cycles held after apply before data resumes (>= 1).
- LANES, 4, MAC lanes per PE (width of the lane mask).
- THERM_HI, 85, temperature at or above which throttling sets.
- THERM_LO, 75, temperature at or below which throttling clears (THERM_LO < THERM_HI).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  configuration request valid
- req_ready  out  1  scheduler can accept a request
- req_precision  in  2  0=INT8 1=INT4 2=INT2 3=INT1
- req_lane_mask  in  LANES  requested active lanes
- req_sparsity_en  in  1  requested sparsity enable
- req_sparsity_mode  in  2  requested sparsity mode
- temperature  in  8  tile temperature, degrees C
- data_valid_in  in  1  upstream data valid
- data_valid_out  out  1  gated data valid to tile
- data_stall  out  1  backpressure to upstream
- precision_mode  out  2  to tile
- lane_active_mask  out  LANES  to tile (effective mask)
- sparsity_enable  out  1  to tile
- sparsity_mode  out  2  to tile
- throttled  out  1  thermal throttle active
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when a sequence completes
- cfg_err  out  1  one-cycle pulse when a zero lane mask is accepted
- switch_count  out  16  completed applies, saturating

Behaviour:
- Reset values, applied asynchronously the moment reset asserts:
  - state IDLE; precision_mode 0; lane_active_mask all-ones; sparsity_enable 0; sparsity_mode 0.
  - throttled 0, busy 0, done 0, cfg_err 0, switch_count 0; internal counters 0.
  - req_ready 1 once reset deasserts.
- Reset mid-sequence abandons the sequence. The latched request is lost; no done pulse.
- FSM states: IDLE, DRAIN, APPLY, SETTLE.
- req_ready = (state==IDLE) and no pending throttle change. A request is accepted on an edge where req_valid & req_ready; the request fields are latched on that edge.
- A zero req_lane_mask is latched as lowest-lane-only (0...01). cfg_err pulses in the cycle after acceptance.
- Thermal hysteresis:
  - throttled_next = 1 if temperature >= THERM_HI.
  - throttled_next = 0 if temperature <= THERM_LO.
  - Otherwise it holds its value.
  - It is registered every cycle in every state. A difference between it and the applied throttle state is a pending throttle change.
- IDLE:
  - A request is accepted -> DRAIN.
  - Else, a pending throttle change -> DRAIN with the current configuration re-latched (internal sequence).
  - A request and a throttle change in the same cycle: the request wins, and the new throttle state is folded into the same APPLY.
- DRAIN: counter runs 0..DRAIN_CYCLES-1, then -> APPLY.
- APPLY (one cycle):
  - At the exit edge, update all four tile control outputs together.
  - Capture the throttle state.
  - Increment switch_count, saturating at 0xFFFF.
  - -> SETTLE.
- SETTLE: counter runs 0..SETTLE_CYCLES-1, then -> IDLE. done pulses in the first IDLE cycle.
- Effective lane_active_mask = latched mask AND (throttled ? lower-half-lanes mask : all-ones). A zero result is replaced by 0...01, with no cfg_err.
- data_stall = busy = (state != IDLE), decoded from the state register.
- data_valid_out = data_valid_in & ~data_stall. Upstream holds data while stalled.
- Latency from the accept edge to done high: DRAIN_CYCLES + 1 + SETTLE_CYCLES cycles (13 with defaults).
  - Outputs change DRAIN_CYCLES + 1 cycles after acceptance.
  - The tile never sees data_valid within DRAIN_CYCLES cycles before or SETTLE_CYCLES cycles after an output change.
- req_valid held during a sequence is not accepted until IDLE. Back-to-back requests therefore cost the full latency each.
- A temperature crossing during a sequence is applied at APPLY if it is already registered. Otherwise it becomes pending and triggers another internal sequence from IDLE.

Decomposition:
- neuraedge_tile_pkg holds:
  - the FSM state enum;
  - precision encodings (PREC_INT8..PREC_INT1);
  - the default thermal thresholds;
  - the lane-mask helper constants (all-ones, lower half, lowest lane).
- One sub-module, tile_thermal_throttle: registered hysteresis comparator with inputs temperature, THERM_HI and THERM_LO, and output throttled_next.

Test Plan:
1. Reset, then req {prec=1, mask=F, sp_en=1, sp_mode=2} -> outputs change 9 cycles after accept; done at +13; switch_count=1; data_valid_out=0 throughout while data_valid_in=1.
2. req mask=0 -> cfg_err pulse at +1; lane_active_mask=0001 after apply.
3. temperature 50->90 while IDLE -> internal sequence; req_ready=0 during it; mask F->0011 after 9 cycles; then 80 -> no change; 70 -> mask back to F after a second sequence.
4. req_valid asserted in the same cycle temperature reaches 90 -> exactly one sequence; final mask = req_mask & 0011; switch_count +1.
5. Assert reset during DRAIN (cycle 3) -> all outputs return to their reset values immediately; no done pulse; req_ready=1 after release.
6. 65540 back-to-back requests (or force the counter near the limit) -> switch_count saturates at 0xFFFF; every request yields one done pulse.
